dffsr_init_sequencer: RTL and testbench

DFFSR_INIT_SEQUENCER -- requirements
Module: dffsr_init_sequencer

---
 rtl/dffsr_ctl_pkg.sv | 27 ++
 rtl/dffsr_phase_timer.sv | 35 +++
 rtl/dffsr_init_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dffsr_init_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffsr_ctl_pkg.sv
// Shared definitions for the dffsr bank init sequencer: FSM states, op encoding
// and parameter helpers.
package dffsr_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_PULSE,
        ST_RECOVER,
        ST_UNGATE
    } seq_state_t;

    localparam logic OP_CLEAR  = 1'b0;
    localparam logic OP_PRESET = 1'b1;

    // Zero-length phases are stretched to one cycle.
    function automatic int eff_cyc(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dffsr_phase_timer.sv
// Loadable down-counter shared by all timed phases; expire_o flags terminal count
// and the counter parks at zero instead of wrapping.
module dffsr_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk_i,
    input  logic          rn_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/dffsr_init_sequencer.sv
// Sequencer that gates a dffsrn bank clock, pulses its RN or SN low, then
// restores the clock, one bank at a time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; illegal bank index raises err
// ST_GATE    | bank clock enable dropped, waiting GATE_CYC cycles
// ST_PULSE   | bank RN (clear) or SN (preset) held low for PULSE_CYC cycles
// ST_RECOVER | RN/SN released, waiting REC_CYC cycles
// ST_UNGATE  | clock enable restored and done pulsed on the way to IDLE
module dffsr_init_sequencer
    import dffsr_ctl_pkg::*;
#(
    parameter int NBANK     = 4,
    parameter int GATE_CYC  = 2,
    parameter int PULSE_CYC = 3,
    parameter int REC_CYC   = 2
) (
    input  logic                                           CLK,
    input  logic                                           RN,
    input  logic                                           req_valid,
    input  logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0]   req_bank,
    input  logic                                           req_op,
    output logic                                           req_ready,
    output logic [NBANK-1:0]                               bank_rn,
    output logic [NBANK-1:0]                               bank_sn,
    output logic [NBANK-1:0]                               bank_clken,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           err
);

    localparam int BW      = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int G_EFF   = eff_cyc(GATE_CYC);
    localparam int P_EFF   = eff_cyc(PULSE_CYC);
    localparam int R_EFF   = eff_cyc(REC_CYC);
    localparam int MAX_EFF = max3(G_EFF, P_EFF, R_EFF);
    localparam int CW      = $clog2(MAX_EFF + 1);

    // The timer expires on its N-th cycle after load, so it is loaded with N-1.
    localparam logic [CW-1:0] G_LOAD = CW'(G_EFF - 1);
    localparam logic [CW-1:0] P_LOAD = CW'(P_EFF - 1);
    localparam logic [CW-1:0] R_LOAD = CW'(R_EFF - 1);

    seq_state_t        state_q, state_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic              op_q, op_d;
    logic [NBANK-1:0]  bank_rn_q, bank_rn_d;
    logic [NBANK-1:0]  bank_sn_q, bank_sn_d;
    logic [NBANK-1:0]  bank_clken_q, bank_clken_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_expire;
    logic              req_legal;

    assign req_legal = ({1'b0, req_bank} < (BW + 1)'(NBANK));

    dffsr_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk_i      (CLK),
        .rn_i       (RN),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        op_d         = op_q;
        bank_clken_d = bank_clken_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        bank_d   = req_bank;
                        op_d     = req_op;
                        state_d  = ST_GATE;
                        tmr_load = 1'b1;
                        tmr_val  = G_LOAD;
                        for (int i = 0; i < NBANK; i++) begin
                            if (req_bank == BW'(i)) bank_clken_d[i] = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (tmr_expire) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = P_LOAD;
                end
            end
            ST_PULSE: begin
                if (tmr_expire) begin
                    state_d  = ST_RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = R_LOAD;
                end
            end
            ST_RECOVER: begin
                if (tmr_expire) state_d = ST_UNGATE;
            end
            ST_UNGATE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                for (int i = 0; i < NBANK; i++) begin
                    if (bank_q == BW'(i)) bank_clken_d[i] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // RN/SN are registered off the next state so they are low exactly while in PULSE.
        for (int i = 0; i < NBANK; i++) begin
            bank_rn_d[i] = !((state_d == ST_PULSE) && (bank_d == BW'(i)) && (op_d == OP_CLEAR));
            bank_sn_d[i] = !((state_d == ST_PULSE) && (bank_d == BW'(i)) && (op_d == OP_PRESET));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q      <= ST_IDLE;
            bank_q       <= '0;
            op_q         <= OP_CLEAR;
            bank_rn_q    <= '1;
            bank_sn_q    <= '1;
            bank_clken_q <= '1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            op_q         <= op_d;
            bank_rn_q    <= bank_rn_d;
            bank_sn_q    <= bank_sn_d;
            bank_clken_q <= bank_clken_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign bank_rn    = bank_rn_q;
    assign bank_sn    = bank_sn_q;
    assign bank_clken = bank_clken_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dffsr_init_sequencer.sv
// Directed bench for dffsr_init_sequencer. Five banks are instantiated so that a
// 3-bit bank index can address the out-of-range banks 5 and 7.
module tb_dffsr_init_sequencer;

    localparam int NB = 5;
    localparam int BW = 3;

    // Sequence timing at default phase lengths, counted in cycles after the accept edge.
    localparam int GATE_ON   = 1;
    localparam int P_START   = 3;
    localparam int P_END     = 5;
    localparam int GATE_OFF  = 8;
    localparam int DONE_AT   = 9;

    logic          CLK = 1'b0;
    logic          RN;
    logic          req_valid;
    logic [BW-1:0] req_bank;
    logic          req_op;
    logic          req_ready;
    logic [NB-1:0] bank_rn;
    logic [NB-1:0] bank_sn;
    logic [NB-1:0] bank_clken;
    logic          busy;
    logic          done;
    logic          err;

    int checks    = 0;
    int fails     = 0;
    int inv_viol  = 0;

    dffsr_init_sequencer #(
        .NBANK     (NB),
        .GATE_CYC  (2),
        .PULSE_CYC (3),
        .REC_CYC   (2)
    ) dut (
        .CLK        (CLK),
        .RN         (RN),
        .req_valid  (req_valid),
        .req_bank   (req_bank),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .bank_rn    (bank_rn),
        .bank_sn    (bank_sn),
        .bank_clken (bank_clken),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    // Expected {busy, ready, done, err, clken, rn, sn} at cycle k for up to two
    // sequences accepted at edges a0/a1 (negative = no sequence).
    function automatic logic [19:0] exp_vec(input int k,
                                            input int a0, input int b0, input logic op0,
                                            input int a1, input int b1, input logic op1);
        logic [NB-1:0] ck, rn, sn;
        logic          bsy, dn;
        int            a, b, rel;
        logic          op;
        ck = '1; rn = '1; sn = '1; bsy = 1'b0; dn = 1'b0;
        for (int s = 0; s < 2; s++) begin
            a  = (s == 0) ? a0 : a1;
            b  = (s == 0) ? b0 : b1;
            op = (s == 0) ? op0 : op1;
            if (a >= 0) begin
                rel = k - a;
                if (rel >= GATE_ON && rel <= GATE_OFF) begin
                    ck[b] = 1'b0;
                    bsy   = 1'b1;
                end
                if (rel >= P_START && rel <= P_END) begin
                    if (op) sn[b] = 1'b0;
                    else    rn[b] = 1'b0;
                end
                if (rel == DONE_AT) dn = 1'b1;
            end
        end
        return {bsy, ~bsy, dn, 1'b0, ck, rn, sn};
    endfunction

    always @(negedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (!bank_rn[i] && !bank_sn[i]) begin
                inv_viol++;
                $display("FAIL inv_rn_sn_both_low bank=%0d t=%0t rn=%b sn=%b", i, $time, bank_rn, bank_sn);
            end
            if ((!bank_rn[i] || !bank_sn[i]) && bank_clken[i]) begin
                inv_viol++;
                $display("FAIL inv_pulse_while_clocked bank=%0d t=%0t clken=%b rn=%b sn=%b",
                         i, $time, bank_clken, bank_rn, bank_sn);
            end
        end
    end

    task automatic test_reset();
        logic [19:0] got, exp;
        RN = 1'b0; req_valid = 1'b0; req_bank = '0; req_op = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        exp = exp_vec(0, -1, 0, 1'b0, -1, 0, 1'b0);
        got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        RN = 1'b1;
        @(posedge CLK); #1;
        got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_release_idle got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_clear_bank2();
        logic [19:0] got, exp;
        req_valid = 1'b1; req_bank = 3'd2; req_op = 1'b0;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            exp = exp_vec(k, 0, 2, 1'b0, -1, 0, 1'b0);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL clear_bank2 cycle=%0d got=%h exp=%h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_preset_bank0();
        logic [19:0] got, exp;
        req_valid = 1'b1; req_bank = 3'd0; req_op = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            exp = exp_vec(k, 0, 0, 1'b1, -1, 0, 1'b0);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL preset_bank0 cycle=%0d got=%h exp=%h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal_bank();
        logic [19:0] got, exp;
        logic [BW-1:0] bad [2];
        bad[0] = 3'd5;
        bad[1] = 3'd7;
        for (int t = 0; t < 2; t++) begin
            req_valid = 1'b1; req_bank = bad[t]; req_op = t[0];
            @(posedge CLK); #1;
            req_valid = 1'b0;
            exp = {1'b0, 1'b1, 1'b0, 1'b1, {NB{1'b1}}, {NB{1'b1}}, {NB{1'b1}}};
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL illegal_err_pulse bank=%0d got=%h exp=%h", bad[t], got, exp);
            end
            @(posedge CLK); #1;
            exp = exp_vec(0, -1, 0, 1'b0, -1, 0, 1'b0);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL illegal_err_clears bank=%0d got=%h exp=%h", bad[t], got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got, exp;
        req_valid = 1'b1; req_bank = 3'd1; req_op = 1'b0;
        @(posedge CLK); #1;
        req_bank = 3'd3; req_op = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            exp = exp_vec(k, 0, 1, 1'b0, DONE_AT, 3, 1'b1);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL back_to_back cycle=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == DONE_AT + 1) req_valid = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [19:0] got, exp;
        req_valid = 1'b1; req_bank = 3'd2; req_op = 1'b0;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = exp_vec(k, 0, 2, 1'b0, -1, 0, 1'b0);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL midrst_pre cycle=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 4) RN = 1'b0;
            @(posedge CLK); #1;
        end
        exp = exp_vec(0, -1, 0, 1'b0, -1, 0, 1'b0);
        got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL midrst_abort got=%h exp=%h", got, exp);
        end
        RN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL midrst_no_done cycle=%0d got=%h exp=%h", k, got, exp);
            end
        end
        req_valid = 1'b1; req_bank = 3'd4; req_op = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            exp = exp_vec(k, 0, 4, 1'b1, -1, 0, 1'b0);
            got = {busy, req_ready, done, err, bank_clken, bank_rn, bank_sn};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL midrst_fresh cycle=%0d got=%h exp=%h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_clear_bank2();
        test_preset_bank0();
        test_illegal_bank();
        test_back_to_back();
        test_reset_mid_pulse();
        checks++;
        if (inv_viol !== 0) begin
            fails++;
            $display("FAIL bank_invariants violations=%0d required=0", inv_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
